// File: rtl/nfa_stream_matcher.sv
// Multi-lane shift-and NFA string matcher over a valid/ready text stream.
// Hits become {lane bitmap, position} events in a small FIFO; text stalls while that FIFO is full.
module nfa_stream_matcher #(
  parameter int DWIDTH     = 8,
  parameter int PLEN       = 16,
  parameter int CHANNELS   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int POS_W      = 16,
  localparam int LANE_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int IDX_W     = (PLEN > 1) ? $clog2(PLEN) : 1,
  localparam int LEN_W     = $clog2(PLEN) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [LANE_W-1:0]   cfg_lane,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [DWIDTH-1:0]   cfg_char,
  input  logic                cfg_len_we,
  input  logic [LEN_W-1:0]    cfg_len,
  input  logic                nocase,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DWIDTH-1:0]   in_char,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CHANNELS-1:0] out_hit,
  output logic [POS_W-1:0]    out_pos,
  output logic                busy,
  output logic                done
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [DWIDTH-1:0]   pat_q [CHANNELS][PLEN];
  logic [LEN_W-1:0]    len_q [CHANNELS];
  logic [PLEN-1:0]     s_q   [CHANNELS];
  logic [PLEN-1:0]     s_d   [CHANNELS];
  logic [PLEN-1:0]     match [CHANNELS];
  logic [CHANNELS-1:0] hit;
  logic [POS_W-1:0]    pos_q;
  logic                nocase_q;
  logic [CHANNELS-1:0] fifo_hit_q [FIFO_DEPTH];
  logic [POS_W-1:0]    fifo_pos_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                start_go, accept, push, pop;
  logic [DWIDTH-1:0]   in_fold;

  // ASCII upper case folds to lower case; only meaningful for 8-bit characters.
  function automatic logic [DWIDTH-1:0] fold(input logic [DWIDTH-1:0] c, input logic fold_en);
    logic [DWIDTH-1:0] r;
    r = c;
    if (fold_en && DWIDTH == 8 && c >= DWIDTH'(8'h41) && c <= DWIDTH'(8'h5A))
      r = c | DWIDTH'(8'h20);
    return r;
  endfunction

  assign start_go  = (state_q == ST_IDLE) && start;
  assign in_ready  = (state_q == ST_RUN) && (cnt_q < CNT_W'(FIFO_DEPTH));
  assign accept    = in_valid && in_ready;
  assign in_fold   = fold(in_char, nocase_q);
  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid && out_ready;
  assign push      = accept && (hit != '0);
  assign out_hit   = out_valid ? fifo_hit_q[rd_ptr_q] : '0;
  assign out_pos   = out_valid ? fifo_pos_q[rd_ptr_q] : '0;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DRAIN) && (cnt_q == '0);

  // Bit k of a lane's state means "pattern prefix of length k+1 ends at this character".
  always_comb begin
    hit = '0;
    for (int l = 0; l < CHANNELS; l++) begin
      match[l] = '0;
      for (int k = 0; k < PLEN; k++)
        match[l][k] = (fold(pat_q[l][k], nocase_q) == in_fold) && (LEN_W'(k) < len_q[l]);
      s_d[l] = ((s_q[l] << 1) | PLEN'(1)) & match[l];
      for (int k = 0; k < PLEN; k++)
        if (LEN_W'(k + 1) == len_q[l]) hit[l] = s_d[l][k];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (accept && in_last) state_d = ST_DRAIN;
      ST_DRAIN: if (cnt_q == '0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int l = 0; l < CHANNELS; l++) begin
        len_q[l] <= '0;
        s_q[l]   <= '0;
        for (int k = 0; k < PLEN; k++) pat_q[l][k] <= '0;
      end
    end else begin
      if (state_q == ST_IDLE && cfg_we)
        pat_q[cfg_lane][cfg_idx] <= cfg_char;
      if (state_q == ST_IDLE && cfg_len_we)
        len_q[cfg_lane] <= (cfg_len > LEN_W'(PLEN)) ? LEN_W'(PLEN) : cfg_len;
      for (int l = 0; l < CHANNELS; l++) begin
        if (start_go)    s_q[l] <= '0;
        else if (accept) s_q[l] <= s_d[l];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      pos_q    <= '0;
      nocase_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (start_go) begin
        pos_q    <= '0;
        nocase_q <= nocase;
      end else if (accept) begin
        pos_q <= pos_q + POS_W'(1);
      end
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push != pop) cnt_q <= push ? cnt_q + CNT_W'(1) : cnt_q - CNT_W'(1);
    end
  end

  // Event storage is never read while empty, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_hit_q[wr_ptr_q] <= hit;
      fifo_pos_q[wr_ptr_q] <= pos_q;
    end
  end

endmodule

// File: doc/nfa_stream_matcher.md
NFA_STREAM_MATCHER -- requirements
Module: nfa_stream_matcher

Interface
REQ-001 Parameter DWIDTH, default 8: character width in bits.
REQ-002 Parameter PLEN, default 16: maximum pattern length per lane, and the NFA state bits per lane.
REQ-003 Parameter CHANNELS, default 16: number of independent pattern lanes.
REQ-004 Parameter FIFO_DEPTH, default 8: depth of the hit-event FIFO; power of 2, at least 2.
REQ-005 Parameter POS_W, default 16: width of the text position counter.
REQ-006 clk  in  1  sole clock; all state changes on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-008 cfg_we  in  1  write one pattern character; honoured only in IDLE.
REQ-009 cfg_lane  in  clog2(CHANNELS)  target lane of the write.
REQ-010 cfg_idx  in  clog2(PLEN)  character index within the pattern.
REQ-011 cfg_char  in  DWIDTH  pattern character.
REQ-012 cfg_len_we  in  1  write the lane length from cfg_len; honoured only in IDLE.
REQ-013 cfg_len  in  clog2(PLEN)+1  pattern length; 0 disables the lane.
REQ-014 nocase  in  1  case-fold mode, sampled on an accepted start.
REQ-015 start  in  1  one-cycle pulse; IDLE->RUN.
REQ-016 in_valid / in_ready / in_char[DWIDTH] / in_last  in/out/in/in  text stream with a valid/ready handshake.
REQ-017 out_valid / out_ready  out/in  hit-event handshake.
REQ-018 out_hit  out  CHANNELS  bitmap of lanes that matched at out_pos.
REQ-019 out_pos  out  POS_W  0-based text index of the last character of the match.
REQ-020 busy  out  1  high in RUN or DRAIN.
REQ-021 done  out  1  one-cycle pulse when DRAIN completes.

Function
REQ-022 FSM states are IDLE, RUN and DRAIN. IDLE->RUN on start. RUN->DRAIN on accepting a beat with in_last=1. DRAIN->IDLE when the FIFO is empty; done=1 in that transition cycle. start is ignored outside IDLE.
REQ-023 On IDLE->RUN: clear all lane state vectors, clear the position counter to 0, and latch nocase.
REQ-024 in_ready = (state==RUN) && (FIFO count < FIFO_DEPTH). in_ready is never high in IDLE or DRAIN.
REQ-025 A beat is accepted when in_valid && in_ready. Per lane: S_next = ((S<<1)|1) & M, where M[k] = (in_char == pat[k]) && (k < len).
REQ-026 With latched nocase=1 and DWIDTH=8, both in_char and pat[k] fold 0x41-0x5A to 0x61-0x7A before comparison.
REQ-027 Lane hit = S_next[len-1] for len >= 1. A lane with len=0 never hits. cfg_len > PLEN is stored as PLEN.
REQ-028 If any lane hits on an accepted beat, push {hit bitmap, pos} into the FIFO. Beats with no hit push nothing. pos increments by 1 per accepted beat and wraps mod 2^POS_W.
REQ-029 Latency: a hit on the beat accepted at edge t is presented on out_valid after edge t, i.e. visible in cycle t+1 when the FIFO was empty.
REQ-030 FIFO pops on out_valid && out_ready. out_hit and out_pos hold stable while out_valid && !out_ready. A simultaneous push and pop leaves the count unchanged.
REQ-031 Backpressure guarantees no push when full. A push in the cycle count reaches FIFO_DEPTH is impossible by REQ-024.
REQ-032 Overlapping matches are all reported: pattern "aa" on text "aaa" hits at pos 1 and pos 2.

Reset
REQ-033 With reset=0 asynchronously: state=IDLE, all pattern characters=0, all lengths=0, S=0, pos=0, FIFO empty, nocase latch=0.
REQ-034 With reset=0 asynchronously: outputs in_ready=0, out_valid=0, out_hit=0, out_pos=0, busy=0, done=0.
REQ-035 Reset mid-RUN or mid-DRAIN discards FIFO contents and configuration. No done pulse is issued.

Verification
REQ-036 Lane0 = "abc" (len 3), start, stream "xabcabc" with in_last on the final beat -> hits 0x0001 @ pos 3 and @ pos 6; done occurs 1 cycle after the last pop.
REQ-037 Lane0 = "ab", lane1 = "b", text "ab" -> single event out_hit=0x0003, out_pos=1.
REQ-038 Lane2 = "Hi", nocase=1 at start, text "hI" -> hit 0x0004 @ pos 1. The same run with nocase=0 produces no event.
REQ-039 FIFO_DEPTH=8, lane0 = "a", out_ready=0, stream 10 'a' -> in_ready drops after 8 accepted beats. Raising out_ready drains pos 0..9 in order with none lost.
REQ-040 POS_W=4, lane0 = "z", 17 beats, 'z' at beats 0 and 16 -> out_pos values 0 then 0 (wrap).
REQ-041 Reset asserted during RUN with 3 queued events -> out_valid=0 and busy=0 immediately. After release, cfg_len reads as disabled: a new run with text "abc" gives no hits.
